// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP OPMODE sequencer.
//   seq_state_t  : sequencer FSM state
//   seq_entry_t  : one program entry {op, cnt} at the default repeat width
//   IDLE_OP_DEF  : OPMODE value driven while no run is in progress
package dsp_seq_pkg;

  localparam int          SEQ_CNTW    = 8;
  localparam logic [7:0]  IDLE_OP_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [7:0]          op;
    logic [SEQ_CNTW-1:0] cnt;
  } seq_entry_t;

endpackage

// File: rtl/opmode_prog_mem.sv
// Program store for the OPMODE sequencer: DEPTH x W register file.
//   clk, rst_n : clock, async active-low clear (all entries to zero)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module opmode_prog_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dsp_opmode_sequencer.sv
// Programmable OPMODE sequencer for a DSP48A1-style slice.
// A host loads (opmode, repeat) entries, pulses START, and each entry's
// opmode is issued for repeat+1 cycles on OPMODE with CEOPMODE high.
//   CLK, RSTN            : clock, async active-low reset
//   WE, WADDR, WOP, WCNT : program-entry write (accepted only while idle)
//   LASTIDX              : final entry index of the run, sampled at START
//   START, ABORT         : begin run / terminate run immediately
//   OPMODE, CEOPMODE     : registered drive into the slice
//   BUSY, DONE, IDX      : run status, completion pulse, current entry
//
// state | meaning
// IDLE  | waiting for START; program writes accepted
// RUN   | issuing mem[IDX].op, counting down its repeat
// FIN   | one-cycle DONE pulse, then back to IDLE
module dsp_opmode_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter int         CNTW    = 8,
  parameter logic [7:0] IDLE_OP = IDLE_OP_DEF
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     WE,
  input  logic [$clog2(DEPTH)-1:0] WADDR,
  input  logic [7:0]               WOP,
  input  logic [CNTW-1:0]          WCNT,
  input  logic [$clog2(DEPTH)-1:0] LASTIDX,
  input  logic                     START,
  input  logic                     ABORT,
  output logic [7:0]               OPMODE,
  output logic                     CEOPMODE,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [$clog2(DEPTH)-1:0] IDX
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 8 + CNTW;

  seq_state_t    state, state_n;
  logic [AW-1:0] idx, idx_n, last, last_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [7:0]    op, op_n;
  logic          ce, ce_n, busy, busy_n, done, done_n;

  logic          mem_we;
  logic [AW-1:0] rd_addr;
  logic [EW-1:0] mem_rdata, rd_entry;
  logic [7:0]    rd_op;
  logic [CNTW-1:0] rd_cnt;

  assign mem_we = WE && (state == IDLE);

  opmode_prog_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (CLK),
    .rst_n (RSTN),
    .we    (mem_we),
    .waddr (WADDR),
    .wdata ({WOP, WCNT}),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // Read address is the entry that will be issued next: entry 0 when a run
  // starts, idx+1 when the current entry expires.
  always_comb begin
    rd_addr = idx;
    if (state == IDLE)
      rd_addr = '0;
    else if (state == RUN && cnt == '0)
      rd_addr = idx + AW'(1);
  end

  // A write in the START cycle is forwarded so the run sees the new entry.
  always_comb begin
    rd_entry = mem_rdata;
    if (mem_we && WADDR == rd_addr)
      rd_entry = {WOP, WCNT};
  end

  assign rd_op  = rd_entry[EW-1:CNTW];
  assign rd_cnt = rd_entry[CNTW-1:0];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    last_n  = last;
    cnt_n   = cnt;
    op_n    = op;
    ce_n    = ce;
    busy_n  = busy;
    done_n  = 1'b0;

    if (ABORT) begin
      state_n = IDLE;
      idx_n   = '0;
      op_n    = IDLE_OP;
      ce_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            state_n = RUN;
            idx_n   = '0;
            last_n  = LASTIDX;
            cnt_n   = rd_cnt;
            op_n    = rd_op;
            ce_n    = 1'b1;
            busy_n  = 1'b1;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNTW'(1);
          end else if (idx == last) begin
            state_n = FIN;
            op_n    = IDLE_OP;
            ce_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + AW'(1);
            cnt_n = rd_cnt;
            op_n  = rd_op;
          end
        end
        FIN: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          op_n    = IDLE_OP;
          ce_n    = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      idx   <= '0;
      last  <= '0;
      cnt   <= '0;
      op    <= IDLE_OP;
      ce    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      last  <= last_n;
      cnt   <= cnt_n;
      op    <= op_n;
      ce    <= ce_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  assign OPMODE   = op;
  assign CEOPMODE = ce;
  assign BUSY     = busy;
  assign DONE     = done;
  assign IDX      = idx;

endmodule

// File: tb/tb_dsp_opmode_sequencer.sv
// Self-checking bench for dsp_opmode_sequencer: directed scenarios plus
// randomized programs compared against an entry-list reference model.
module tb_dsp_opmode_sequencer;

  localparam int DEPTH = 8;
  localparam int CNTW  = 8;
  localparam int AW    = 3;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            WE;
  logic [AW-1:0]   WADDR;
  logic [7:0]      WOP;
  logic [CNTW-1:0] WCNT;
  logic [AW-1:0]   LASTIDX;
  logic            START;
  logic            ABORT;
  logic [7:0]      OPMODE;
  logic            CEOPMODE;
  logic            BUSY;
  logic            DONE;
  logic [AW-1:0]   IDX;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_op  [DEPTH];
  int         m_cnt [DEPTH];

  always #5 CLK = ~CLK;

  dsp_opmode_sequencer #(.DEPTH(DEPTH), .CNTW(CNTW), .IDLE_OP(8'h00)) dut (
    .CLK(CLK), .RSTN(RSTN), .WE(WE), .WADDR(WADDR), .WOP(WOP), .WCNT(WCNT),
    .LASTIDX(LASTIDX), .START(START), .ABORT(ABORT), .OPMODE(OPMODE),
    .CEOPMODE(CEOPMODE), .BUSY(BUSY), .DONE(DONE), .IDX(IDX)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_outputs(input string tag, input logic exp_done);
    chk({tag, "_op"},   OPMODE,   8'h00);
    chk({tag, "_ce"},   CEOPMODE, 1'b0);
    chk({tag, "_busy"}, BUSY,     1'b0);
    chk({tag, "_done"}, DONE,     exp_done);
  endtask

  task automatic write_entry(input int a, input logic [7:0] op, input int c);
    WE = 1'b1; WADDR = AW'(a); WOP = op; WCNT = CNTW'(c);
    tick;
    WE = 1'b0;
    m_op[a] = op; m_cnt[a] = c;
  endtask

  // Expected trace: each entry 0..last contributes cnt+1 cycles of its op.
  task automatic run_prog(input int last, input int abort_at, input bit noise);
    logic [7:0] eop[$];
    int         eidx[$];
    for (int i = 0; i <= last; i++)
      for (int r = 0; r <= m_cnt[i]; r++) begin
        eop.push_back(m_op[i]);
        eidx.push_back(i);
      end
    START = 1'b1; LASTIDX = AW'(last);
    tick;
    START = 1'b0; WE = 1'b0;
    for (int k = 0; k < eop.size(); k++) begin
      chk("run_op",   OPMODE,   eop[k]);
      chk("run_ce",   CEOPMODE, 1'b1);
      chk("run_busy", BUSY,     1'b1);
      chk("run_idx",  IDX,      eidx[k]);
      chk("run_done", DONE,     1'b0);
      if (k == abort_at) begin
        ABORT = 1'b1;
        tick;
        ABORT = 1'b0;
        idle_outputs("abort", 1'b0);
        chk("abort_idx", IDX, 0);
        tick;
        idle_outputs("abort_after", 1'b0);
        return;
      end
      if (noise) begin
        START = 1'($urandom_range(0, 1));
        WE = 1'($urandom_range(0, 1));
        WADDR = AW'($urandom_range(0, DEPTH-1));
        WOP = 8'($urandom);
        WCNT = CNTW'($urandom);
      end
      tick;
      START = 1'b0; WE = 1'b0;
    end
    idle_outputs("fin", 1'b1);
    if (noise) START = 1'b1;
    tick;
    START = 1'b0;
    idle_outputs("post_fin", 1'b0);
    tick;
    idle_outputs("post_fin2", 1'b0);
  endtask

  initial begin
    RSTN = 1'b0; WE = 1'b0; WADDR = '0; WOP = '0; WCNT = '0;
    LASTIDX = '0; START = 1'b0; ABORT = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_op[i] = 8'h00; m_cnt[i] = 0; end
    #2;
    idle_outputs("reset", 1'b0);
    chk("reset_idx", IDX, 0);
    #10 RSTN = 1'b1;
    tick;

    // Directed program and normal run
    write_entry(0, 8'h1D, 0);
    write_entry(1, 8'h0D, 2);
    write_entry(2, 8'h3F, 1);
    run_prog(2, -1, 1'b0);

    // Abort on third RUN cycle, then restart from entry 0
    run_prog(2, 2, 1'b0);
    run_prog(2, -1, 1'b0);

    // Write entry 0 in the START cycle, single-entry run
    WE = 1'b1; WADDR = '0; WOP = 8'hA5; WCNT = '0;
    m_op[0] = 8'hA5; m_cnt[0] = 0;
    run_prog(0, -1, 1'b0);

    // Writes (and START) during RUN/FIN are ignored; entry 1 still original
    write_entry(0, 8'h1D, 0);
    run_prog(2, -1, 1'b1);
    run_prog(2, -1, 1'b0);

    // Longest entry: 256 cycles
    write_entry(0, 8'h77, 255);
    run_prog(0, -1, 1'b1);

    // Randomized programs
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, 8'($urandom), int'($urandom_range(0, 4)));
      run_prog(int'($urandom_range(0, DEPTH-1)), -1, 1'($urandom_range(0, 1)));
    end

    // Async reset mid-run, then memory must read back as zero
    write_entry(0, 8'h5A, 6);
    START = 1'b1; LASTIDX = '0;
    tick;
    START = 1'b0;
    tick;
    chk("pre_rst_busy", BUSY, 1'b1);
    #2 RSTN = 1'b0;
    #1;
    idle_outputs("async_rst", 1'b0);
    chk("async_rst_idx", IDX, 0);
    #2 RSTN = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin m_op[i] = 8'h00; m_cnt[i] = 0; end
    tick;
    run_prog(3, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_opmode_sequencer.md
# dsp_opmode_sequencer

Issuing side of the DSP slice's OPMODE register: a small programmable sequencer that drives an 8-bit OPMODE word and its clock enable into the slice's OPMODE/CEOPMODE inputs. A host loads a program of (opmode, repeat) entries, pulses START, and the block issues each opmode for repeat+1 cycles, then signals DONE. It sits between host control logic and the DSP48A1-style datapath.

## Interface
- DEPTH, 8, number of program entries (power of two, ≥2)
- CNTW, 8, width of per-entry repeat count
- IDLE_OP, 8'h00, OPMODE value driven while not running
- CLK  in  1  rising-edge clock
- RSTN  in  1  asynchronous, active-low reset
- WE  in  1  program-entry write strobe
- WADDR  in  $clog2(DEPTH)  entry index to write
- WOP  in  8  opmode field of written entry
- WCNT  in  CNTW  repeat field of written entry (entry issued WCNT+1 cycles)
- LASTIDX  in  $clog2(DEPTH)  index of final entry of the run, sampled at START
- START  in  1  begin run (level sampled each edge)
- ABORT  in  1  terminate run immediately
- OPMODE  out  8  registered opmode to DSP slice
- CEOPMODE  out  1  registered enable to DSP OPMODE register
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse on normal completion
- IDX  out  $clog2(DEPTH)  entry currently issued

## Operation
- States: IDLE, RUN, FIN.
- IDLE: OPMODE=IDLE_OP, CEOPMODE=0, BUSY=0. START=1 → RUN, IDX=0, repeat counter loaded from entry 0, latched last=LASTIDX.
- RUN: OPMODE=mem[IDX].op, CEOPMODE=1, BUSY=1. Counter decrements each cycle; at 0: if IDX==last → FIN, else IDX+1 and reload counter.
- FIN: one cycle, DONE=1, BUSY=0, CEOPMODE=0, OPMODE=IDLE_OP → IDLE. START ignored in FIN.
- ABORT: highest priority in any state; next state IDLE, no DONE pulse, IDX=0.
- START while RUN or FIN: ignored.
- WE: honoured only in IDLE; ignored in RUN/FIN. WE and START in same IDLE cycle: write committed and bypassed, so the run uses the new data if WADDR=0.
- Repeat counter is CNTW bits, unsigned; WCNT=all-ones gives 2^CNTW cycles, no overflow.
- Program memory persists across runs; cleared to zero by reset.

## Timing
- All outputs registered. Reset (RSTN=0, async): OPMODE=IDLE_OP, CEOPMODE=0, BUSY=0, DONE=0, IDX=0, state IDLE, memory zeroed.
- START sampled at edge t → first opmode valid after edge t (cycle t+1).
- Run length = Σ(cnt_i+1) over entries 0..last; BUSY high exactly that many cycles; DONE high the cycle immediately after; next START accepted the cycle after DONE.
- ABORT sampled at edge t → OPMODE=IDLE_OP, CEOPMODE=0, BUSY=0 after edge t.
- RSTN asserted mid-run: outputs go to reset values immediately, without waiting for CLK.

## Structure
- Package dsp_seq_pkg: state enum (IDLE, RUN, FIN), entry struct {op[7:0], cnt[CNTW-1:0]}, default IDLE_OP constant.
- Sub-module opmode_prog_mem: DEPTH×(8+CNTW) register file, one synchronous write port, one combinational read port, async active-low clear.
- Top holds FSM, repeat counter, index register, output registers, write bypass.

## Test plan
- Reset mid-run: assert RSTN=0 during RUN → OPMODE=8'h00, CEOPMODE=0, BUSY=0 asynchronously; memory reads zero.
- Load {0:(8'h1D,0),1:(8'h0D,2),2:(8'h3F,1)}, LASTIDX=2, START → OPMODE 1D,0D,0D,0D,3F,3F with CEOPMODE=1, BUSY 6 cycles, then DONE one cycle.
- ABORT on third RUN cycle of above → next cycle OPMODE=00, BUSY=0, no DONE; START restarts at entry 0.
- WE to entry 0 (8'hA5,0) in same cycle as START, LASTIDX=0 → single cycle OPMODE=A5 then DONE.
- WE during RUN to entry 1 → ignored; following run still issues original entry 1.
- Entry 0 cnt=8'hFF, LASTIDX=0 → BUSY exactly 256 cycles; START pulses during RUN/FIN ignored.
